// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns a raw instruction into the ALU/branch/operand/memory control bundle
// behind a valid/ready handshake with a 2-entry (output + skid) buffer and an illegal counter.
module alu_decode_stage #(
    parameter logic [5:0] ILLEGAL_CTRL = 6'b000000,
    parameter int         CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction_in,
    input  logic [31:0]      pc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       ALU_Control,
    output logic             branch_op,
    output logic [31:0]      imm_out,
    output logic [1:0]       op_a_sel,
    output logic             op_b_sel,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             illegal,
    output logic [31:0]      pc_out,
    output logic [CNT_W-1:0] illegal_count
);

    typedef struct packed {
        logic [5:0]  alu;
        logic        br;
        logic [31:0] imm;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
        logic [31:0] pc;
    } bundle_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    bundle_t          dec_s;
    bundle_t          out_r;
    bundle_t          skid_r;
    logic             bad_s;
    logic             accept_s;
    logic             out_valid_r;
    logic             skid_valid_r;
    logic             in_ready_r;
    logic [CNT_W-1:0] cnt_r;

    logic [6:0]  opc_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, imm_sh_s;

    assign opc_s    = instruction_in[6:0];
    assign f3_s     = instruction_in[14:12];
    assign f7_s     = instruction_in[31:25];
    assign imm_i_s  = {{20{instruction_in[31]}}, instruction_in[31:20]};
    assign imm_s_s  = {{20{instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]};
    assign imm_b_s  = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                       instruction_in[30:25], instruction_in[11:8], 1'b0};
    assign imm_u_s  = {instruction_in[31:12], 12'h000};
    assign imm_j_s  = {{11{instruction_in[31]}}, instruction_in[31], instruction_in[19:12],
                       instruction_in[20], instruction_in[30:21], 1'b0};
    assign imm_sh_s = {27'd0, instruction_in[24:20]};

    assign accept_s = in_valid & in_ready_r & ~flush;

    // Combinational decode of the presented instruction into a control bundle.
    always_comb begin
        dec_s     = '0;
        bad_s     = 1'b0;
        dec_s.rs1 = instruction_in[19:15];
        dec_s.rs2 = instruction_in[24:20];
        dec_s.rd  = instruction_in[11:7];
        dec_s.pc  = pc_in;
        case (opc_s)
            7'b0110011: begin
                dec_s.rw = 1'b1;
                if (f7_s == 7'b0000000) begin
                    dec_s.alu = {3'b000, f3_s};
                end else if (f7_s == 7'b0100000 && (f3_s == 3'b000 || f3_s == 3'b101)) begin
                    dec_s.alu = {3'b001, f3_s};
                end else begin
                    bad_s = 1'b1;
                end
            end
            7'b0010011: begin
                dec_s.rw    = 1'b1;
                dec_s.b_sel = 1'b1;
                dec_s.imm   = imm_i_s;
                dec_s.alu   = {3'b000, f3_s};
                case (f3_s)
                    3'b001: begin
                        dec_s.imm = imm_sh_s;
                        if (f7_s != 7'b0000000) bad_s = 1'b1;
                        else                    bad_s = 1'b0;
                    end
                    3'b101: begin
                        dec_s.imm = imm_sh_s;
                        if (f7_s == 7'b0100000)      dec_s.alu = 6'b001101;
                        else if (f7_s != 7'b0000000) bad_s = 1'b1;
                        else                         bad_s = 1'b0;
                    end
                    default: bad_s = 1'b0;
                endcase
            end
            7'b0000011: begin
                dec_s.mr    = 1'b1;
                dec_s.rw    = 1'b1;
                dec_s.b_sel = 1'b1;
                dec_s.imm   = imm_i_s;
                if (f3_s == 3'b011 || f3_s[2:1] == 2'b11) bad_s = 1'b1;
                else                                       bad_s = 1'b0;
            end
            7'b0100011: begin
                dec_s.mw    = 1'b1;
                dec_s.b_sel = 1'b1;
                dec_s.imm   = imm_s_s;
                if (f3_s > 3'b010) bad_s = 1'b1;
                else               bad_s = 1'b0;
            end
            7'b1100011: begin
                dec_s.br  = 1'b1;
                dec_s.imm = imm_b_s;
                dec_s.alu = {3'b010, f3_s};
                if (f3_s[2:1] == 2'b01) bad_s = 1'b1;
                else                    bad_s = 1'b0;
            end
            7'b0110111: begin
                dec_s.rw    = 1'b1;
                dec_s.a_sel = 2'b10;
                dec_s.b_sel = 1'b1;
                dec_s.imm   = imm_u_s;
            end
            7'b0010111: begin
                dec_s.rw    = 1'b1;
                dec_s.a_sel = 2'b01;
                dec_s.b_sel = 1'b1;
                dec_s.imm   = imm_u_s;
            end
            7'b1101111: begin
                dec_s.rw    = 1'b1;
                dec_s.alu   = 6'b011111;
                dec_s.a_sel = 2'b11;
                dec_s.b_sel = 1'b1;
                dec_s.imm   = imm_j_s;
            end
            7'b1100111: begin
                dec_s.rw    = 1'b1;
                dec_s.alu   = 6'b111111;
                dec_s.a_sel = 2'b11;
                dec_s.b_sel = 1'b1;
                dec_s.imm   = imm_i_s;
                if (f3_s != 3'b000) bad_s = 1'b1;
                else                bad_s = 1'b0;
            end
            default: bad_s = 1'b1;
        endcase
        // Illegal encodings keep register indices and PC but carry no side effects.
        if (bad_s) begin
            dec_s.alu   = ILLEGAL_CTRL;
            dec_s.br    = 1'b0;
            dec_s.imm   = 32'd0;
            dec_s.a_sel = 2'b00;
            dec_s.b_sel = 1'b0;
            dec_s.rw    = 1'b0;
            dec_s.mr    = 1'b0;
            dec_s.mw    = 1'b0;
            dec_s.ill   = 1'b1;
        end else begin
            dec_s.ill   = 1'b0;
        end
    end

    // Output register plus skid register; in_ready only depends on registered skid occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_r        <= '0;
            skid_r       <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (!out_valid_r || out_ready) begin
            in_ready_r <= 1'b1;
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_r       <= dec_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
            in_ready_r   <= 1'b0;
        end else begin
            in_ready_r <= ~skid_valid_r;
        end
    end

    // Saturating count of accepted illegal instructions; flush does not touch it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (accept_s && dec_s.ill && cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign ALU_Control   = out_r.alu;
    assign branch_op     = out_r.br;
    assign imm_out       = out_r.imm;
    assign op_a_sel      = out_r.a_sel;
    assign op_b_sel      = out_r.b_sel;
    assign rs1           = out_r.rs1;
    assign rs2           = out_r.rs2;
    assign rd            = out_r.rd;
    assign reg_write     = out_r.rw;
    assign mem_read      = out_r.mr;
    assign mem_write     = out_r.mw;
    assign illegal       = out_r.ill;
    assign pc_out        = out_r.pc;
    assign illegal_count = cnt_r;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: expected bundles are queued on acceptance and
// compared when the stage hands them to execute.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        in_ready, out_valid, branch_op, op_b_sel;
    logic        reg_write, mem_read, mem_write, illegal;
    logic [5:0]  alu_ctl;
    logic [31:0] imm_out, pc_out;
    logic [1:0]  op_a_sel;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  illegal_count;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  alu;
        logic        br;
        logic [31:0] imm;
        logic        imm_chk;
        logic [1:0]  a;
        logic        b;
        logic        sel_chk;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic acc_seen = 1'b0;

    alu_decode_stage dut (
        .clock(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction_in(instr), .pc_in(pc), .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Control(alu_ctl), .branch_op(branch_op), .imm_out(imm_out), .op_a_sel(op_a_sel),
        .op_b_sel(op_b_sel), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal), .pc_out(pc_out),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p, input logic [5:0] alu,
                                input logic br, input logic [31:0] imm, input logic imm_chk,
                                input logic [1:0] a, input logic b, input logic sel_chk,
                                input logic rw, input logic mr, input logic mw, input logic ill);
        exp_t e;
        e.instr = i; e.pc = p; e.alu = alu; e.br = br; e.imm = imm; e.imm_chk = imm_chk;
        e.a = a; e.b = b; e.sel_chk = sel_chk; e.rw = rw; e.mr = mr; e.mw = mw; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t mk_ill(input logic [31:0] i, input logic [31:0] p);
        return mk(i, p, 6'b000000, 1'b0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // One clock: scoreboard work on the falling edge, return just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        acc_seen = rst_n && in_valid && in_ready && !flush;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got pc %h required no output", pc_out);
            end else begin
                e = sb.pop_front();
                if (alu_ctl !== e.alu) begin
                    errors++;
                    $display("FAIL alu pc=%h got %b required %b", e.pc, alu_ctl, e.alu);
                end
                checks++;
                if ({branch_op, reg_write, mem_read, mem_write, illegal} !== {e.br, e.rw, e.mr, e.mw, e.ill}) begin
                    errors++;
                    $display("FAIL ctl pc=%h got %b required %b", e.pc,
                             {branch_op, reg_write, mem_read, mem_write, illegal}, {e.br, e.rw, e.mr, e.mw, e.ill});
                end
                checks++;
                if ({rs1, rs2, rd} !== {e.instr[19:15], e.instr[24:20], e.instr[11:7]}) begin
                    errors++;
                    $display("FAIL regs pc=%h got %h required %h", e.pc, {rs1, rs2, rd},
                             {e.instr[19:15], e.instr[24:20], e.instr[11:7]});
                end
                checks++;
                if (pc_out !== e.pc) begin
                    errors++;
                    $display("FAIL order_pc got %h required %h", pc_out, e.pc);
                end
                if (e.imm_chk) begin
                    checks++;
                    if (imm_out !== e.imm) begin
                        errors++;
                        $display("FAIL imm pc=%h got %h required %h", e.pc, imm_out, e.imm);
                    end
                end
                if (e.sel_chk) begin
                    checks++;
                    if ({op_a_sel, op_b_sel} !== {e.a, e.b}) begin
                        errors++;
                        $display("FAIL sel pc=%h got %b required %b", e.pc, {op_a_sel, op_b_sel}, {e.a, e.b});
                    end
                end
            end
        end
        if (flush) sb.delete();
        else if (acc_seen) sb.push_back(cur_exp);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input exp_t e);
        int n;
        n = 0;
        instr = e.instr; pc = e.pc; cur_exp = e; in_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!acc_seen && n < 50);
        if (!acc_seen) begin
            checks++; errors++;
            $display("FAIL accept_timeout pc=%h got no accept required accept", e.pc);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_check(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain got pending %0d out_valid %b required 0 0", name, sb.size(), out_valid);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        sb.delete();
        cycle(); cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({out_valid, in_ready, alu_ctl, imm_out, pc_out, illegal_count, reg_write, illegal} !==
            {1'b0, 1'b1, 6'd0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got v=%b r=%b alu=%b imm=%h pc=%h cnt=%0d required 0 1 0 0 0 0",
                     out_valid, in_ready, alu_ctl, imm_out, pc_out, illegal_count);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        issue(mk(32'h002081B3, 32'h100, 6'b000000, 1'b0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'h100) begin
            errors++;
            $display("FAIL latency got out_valid %b pc %h required 1 00000100", out_valid, pc_out);
        end
        drain_check("latency");
    endtask

    task automatic test_decode();
        exp_t v[11];
        int   c0;
        v[0]  = mk(32'h402081B3, 32'h200, 6'b001000, 1'b0, 32'd0,        1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        v[1]  = mk(32'h40335293, 32'h204, 6'b001101, 1'b0, 32'd3,        1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        v[2]  = mk(32'hFE20DCE3, 32'h208, 6'b010101, 1'b1, 32'hFFFFFFF8, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        v[3]  = mk(32'h123450B7, 32'h20C, 6'b000000, 1'b0, 32'h12345000, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        v[4]  = mk(32'h00001217, 32'h210, 6'b000000, 1'b0, 32'h00001000, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        v[5]  = mk(32'h008000EF, 32'h214, 6'b011111, 1'b0, 32'd8,        1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        v[6]  = mk(32'h00008067, 32'h218, 6'b111111, 1'b0, 32'd0,        1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        v[7]  = mk(32'h0040A103, 32'h21C, 6'b000000, 1'b0, 32'd4,        1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        v[8]  = mk(32'hFE20AE23, 32'h220, 6'b000000, 1'b0, 32'hFFFFFFFC, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        v[9]  = mk(32'hFFF47393, 32'h224, 6'b000111, 1'b0, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        v[10] = mk_ill(32'h0020A063, 32'h228);
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 11; i++) issue(v[i]);
        checks++;
        if (cyc - c0 != 11) begin
            errors++;
            $display("FAIL throughput got %0d cycles required 11", cyc - c0);
        end
        drain_check("decode");
    endtask

    task automatic test_back_to_back();
        exp_t ec;
        out_ready = 1'b0;
        issue(mk(32'h008000EF, 32'h300, 6'b011111, 1'b0, 32'd8, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        issue(mk(32'h402081B3, 32'h304, 6'b001000, 1'b0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        ec = mk(32'hFE20DCE3, 32'h308, 6'b010101, 1'b1, 32'hFFFFFFF8, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        instr = ec.instr; pc = ec.pc; cur_exp = ec; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_out !== 32'h300 || alu_ctl !== 6'b011111) begin
                errors++;
                $display("FAIL stall_hold got ready %b valid %b pc %h alu %b required 0 1 00000300 011111",
                         in_ready, out_valid, pc_out, alu_ctl);
            end
            cycle();
            checks++;
            if (acc_seen) begin
                errors++;
                $display("FAIL third_accept got accepted required stalled");
            end
        end
        out_ready = 1'b1;
        for (int n = 0; n < 20 && !acc_seen; n++) cycle();
        checks++;
        if (!acc_seen) begin
            errors++;
            $display("FAIL third_accept_after_release got none required accept");
        end
        in_valid = 1'b0;
        drain_check("skid");
    endtask

    task automatic test_illegal_count();
        apply_reset();
        out_ready = 1'b1;
        issue(mk_ill(32'hFFFFFFFF, 32'h400));
        checks++;
        if (illegal_count !== 8'd1) begin
            errors++;
            $display("FAIL count_first got %0d required 1", illegal_count);
        end
        for (int i = 0; i < 254; i++) issue(mk_ill(32'hFFFFFFFF, 32'h404 + 32'(i)));
        checks++;
        if (illegal_count !== 8'd255) begin
            errors++;
            $display("FAIL count_max got %0d required 255", illegal_count);
        end
        for (int i = 0; i < 46; i++) issue(mk_ill(32'h0020A063, 32'h800 + 32'(i)));
        checks++;
        if (illegal_count !== 8'd255) begin
            errors++;
            $display("FAIL count_saturate got %0d required 255", illegal_count);
        end
        drain_check("count");
    endtask

    task automatic test_flush();
        logic [7:0] cnt0;
        apply_reset();
        out_ready = 1'b0;
        issue(mk(32'h002081B3, 32'h500, 6'b000000, 1'b0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        issue(mk(32'h402081B3, 32'h504, 6'b001000, 1'b0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        cnt0 = illegal_count;
        instr = 32'hFFFFFFFF; pc = 32'h508; cur_exp = mk_ill(32'hFFFFFFFF, 32'h508);
        in_valid = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== cnt0) begin
            errors++;
            $display("FAIL flush got valid %b ready %b cnt %0d required 0 1 %0d",
                     out_valid, in_ready, illegal_count, cnt0);
        end
        out_ready = 1'b1;
        issue(mk(32'h123450B7, 32'h50C, 6'b000000, 1'b0, 32'h12345000, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        drain_check("flush");
    endtask

    task automatic test_reset_midstall();
        out_ready = 1'b0;
        issue(mk(32'h008000EF, 32'h600, 6'b011111, 1'b0, 32'd8, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        issue(mk_ill(32'hFFFFFFFF, 32'h604));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, alu_ctl, pc_out, imm_out, illegal_count} !==
            {1'b0, 1'b1, 6'd0, 32'd0, 32'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_midstall got v=%b r=%b alu=%b pc=%h imm=%h cnt=%0d required 0 1 0 0 0 0",
                     out_valid, in_ready, alu_ctl, pc_out, imm_out, illegal_count);
        end
        sb.delete();
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drain_check("post_reset");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_decode();
        test_back_to_back();
        test_illegal_count();
        test_flush();
        test_reset_midstall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
